pattern_seq_gen: RTL and testbench

Serial pattern generator: the transmit-side counterpart of the team's sequence detectors. It latches a programmable bit pattern and shifts it out MSB-first, one bit per clock, for a programmed number of repetitions or continuously until stopped. It drives the detector benches and the loopback path feeding the `x` input of the pattern-detector blocks.

---
 rtl/pattern_seq_gen_if.sv | 18 +
 rtl/pattern_seq_gen.sv | 116 +++++++++++
 tb/tb_pattern_seq_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pattern_seq_gen_if.sv
// pattern_seq_gen_if: control inputs and serial outputs of the pattern generator
interface pattern_seq_gen_if #(
  parameter int W  = 8,
  parameter int LW = 3,
  parameter int CW = 4
);
  logic          start;
  logic          stop;
  logic [W-1:0]  pat;
  logic [LW-1:0] len;
  logic [CW-1:0] reps;
  logic          x;
  logic          xv;
  logic          busy;
  logic          done;
  modport master (output start, stop, pat, len, reps, input x, xv, busy, done);
  modport slave (input start, stop, pat, len, reps, output x, xv, busy, done);
endinterface

// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen: shifts a latched pattern out MSB-first for N reps or until stopped
// Define PGEN_GAP_EN to insert one idle cycle between consecutive repetitions.
module pattern_seq_gen #(
  parameter int W  = 8,
  parameter int LW = 3,
  parameter int CW = 4
) (
  input logic              clk,
  input logic              rst,
  pattern_seq_gen_if.slave bus
);
`ifdef PGEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
`endif
  localparam logic [LW-1:0] LMAX = LW'(W - 1);
  state_t        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, len_c;
  logic [CW-1:0] reps_q, reps_d, rep_q, rep_d;
  logic          stopf_q, stopf_d, x_q, x_d, xv_q, xv_d, busy_q, busy_d, done_q, done_d;
  logic          last, fin;
  assign len_c = bus.len > LMAX ? LMAX : bus.len;
  assign last  = idx_q == '0;
  // a run ends after the current repetition when stopped or on the last counted rep
  assign fin   = stopf_q | bus.stop | (reps_q != '0 && rep_q == CW'(1));
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    rep_d   = rep_q;
    stopf_d = stopf_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SEND;
        pat_d   = bus.pat;
        len_d   = len_c;
        idx_d   = len_c;
        reps_d  = bus.reps;
        rep_d   = bus.reps;
        stopf_d = 1'b0;
        x_d     = bus.pat[len_c];
        xv_d    = 1'b1;
        busy_d  = 1'b1;
      end
      SEND: begin
        stopf_d = stopf_q | bus.stop;
        busy_d  = 1'b1;
        if (!last) begin
          idx_d = idx_q - 1'b1;
          x_d   = pat_q[idx_q-1'b1];
          xv_d  = 1'b1;
        end else if (fin) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          idx_d = len_q;
          rep_d = reps_q != '0 ? rep_q - 1'b1 : rep_q;
`ifdef PGEN_GAP_EN
          state_d = GAP;
`else
          x_d  = pat_q[len_q];
          xv_d = 1'b1;
`endif
        end
      end
`ifdef PGEN_GAP_EN
      GAP: begin
        state_d = SEND;
        x_d     = pat_q[idx_q];
        xv_d    = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
      stopf_q <= 1'b0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
      stopf_q <= stopf_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.x    = x_q;
  assign bus.xv   = xv_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_pattern_seq_gen.sv
// tb_pattern_seq_gen: random and directed runs checked every cycle against a stream-queue model
module tb_pattern_seq_gen;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  pattern_seq_gen_if #(.W(8), .LW(3), .CW(4)) bus ();
  pattern_seq_gen #(.W(8), .LW(3), .CW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {logic x, xv, busy, done, last;} ent_t;
  ent_t q[$];
  ent_t e;
  logic [7:0] m_pat;
  int m_len, m_reps, m_rem;
  bit m_stop;

`ifdef PGEN_GAP_EN
  localparam logic [31:0] T1_MASK = 32'h3008, T1_X = 32'h4AAA, T1_XV = 32'h4EEE, T1_B = 32'h5FFE, T1_D = 32'h1000;
  localparam logic [31:0] T2_X = 32'h2954A, T2_XV = 32'h3FDFE, T2_B = 32'h7FFFE, T2_D = 32'h40000;
  localparam logic [31:0] T3_X = 32'hAA, T3_XV = 32'hAA, T3_B = 32'h1FE, T3_D = 32'h100;
  localparam int N1 = 14, N2 = 20, N3 = 9;
`else
  localparam logic [31:0] T1_MASK = 32'hC08, T1_X = 32'h12DA, T1_XV = 32'h13FE, T1_B = 32'h17FE, T1_D = 32'h400;
  localparam logic [31:0] T2_X = 32'h14B4A, T2_XV = 32'h1FFFE, T2_B = 32'h3FFFE, T2_D = 32'h20000;
  localparam logic [31:0] T3_X = 32'h1E, T3_XV = 32'h1E, T3_B = 32'h3E, T3_D = 32'h20;
  localparam int N1 = 12, N2 = 19, N3 = 6;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic x, xv, busy, done, last);
    return '{x: x, xv: xv, busy: busy, done: done, last: last};
  endfunction

  task automatic push_rep();
    for (int i = m_len; i >= 0; i--) q.push_back(mk(m_pat[i], 1'b1, 1'b1, 1'b0, i == 0));
  endtask

  // model: the expected output stream is a queue of per-cycle entries, extended rep by rep
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_x", {31'b0, bus.x}, 0);
      chk("rst_xv", {31'b0, bus.xv}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_done", {31'b0, bus.done}, 0);
    end else begin
      e = q.size() != 0 ? q[0] : '0;
      chk("x", {31'b0, bus.x}, {31'b0, e.x});
      chk("xv", {31'b0, bus.xv}, {31'b0, e.xv});
      chk("busy", {31'b0, bus.busy}, {31'b0, e.busy});
      chk("done", {31'b0, bus.done}, {31'b0, e.done});
      if (q.size() == 0) begin
        if (bus.start) begin
          m_pat = bus.pat;
          m_len = int'(bus.len) > W - 1 ? W - 1 : int'(bus.len);
          m_reps = int'(bus.reps);
          m_rem = m_reps;
          m_stop = 0;
          push_rep();
        end
      end else begin
        void'(q.pop_front());
        if (e.xv && bus.stop) m_stop = 1;
        if (e.last) begin
          if (m_stop || (m_reps != 0 && m_rem == 1)) q.push_back(mk(0, 0, 1, 1, 0));
          else begin
            if (m_reps != 0) m_rem--;
`ifdef PGEN_GAP_EN
            q.push_back(mk(0, 0, 1, 0, 0));
`endif
            push_rep();
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bus.start = 0;
    bus.stop = 0;
    for (int k = 0; k < 300 && bus.busy; k++) @(negedge clk);
    chk("idle_timeout", {31'b0, bus.busy}, 0);
  endtask

  task automatic run(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r, input int stop_at,
                     input logic [31:0] smask, input bit scramble, input int n,
                     output logic [31:0] xs, xvs, bs, ds);
    xs = 0; xvs = 0; bs = 0; ds = 0;
    @(posedge clk);
    #1 bus.pat = p; bus.len = l; bus.reps = r; bus.stop = 0; bus.start = 1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= n; k++) begin
      bus.start = smask[k];
      bus.stop = k == stop_at;
      if (scramble) bus.pat = 8'($urandom) & 8'hFE;
      @(negedge clk);
      xs[k] = bus.x; xvs[k] = bus.xv; bs[k] = bus.busy; ds[k] = bus.done;
      @(posedge clk);
      #1;
    end
    bus.start = 0;
    bus.stop = 0;
  endtask

  initial begin
    logic [31:0] xs, xvs, bs, ds;
    rst = 1;
    bus.start = 0; bus.stop = 0; bus.pat = 0; bus.len = 0; bus.reps = 0;
    repeat (2) @(posedge clk);
    #1 chk("reset_busy", {31'b0, bus.busy}, 0);
    chk("reset_xv", {31'b0, bus.xv}, 0);
    rst = 0;
    run(8'h05, 3'd2, 4'd3, 0, T1_MASK, 0, N1, xs, xvs, bs, ds);
    chk("t1_x", xs, T1_X); chk("t1_xv", xvs, T1_XV); chk("t1_busy", bs, T1_B); chk("t1_done", ds, T1_D);
    wait_idle();
    run(8'hA5, 3'd7, 4'd0, 12, 0, 0, N2, xs, xvs, bs, ds);
    chk("t2_x", xs, T2_X); chk("t2_xv", xvs, T2_XV); chk("t2_busy", bs, T2_B); chk("t2_done", ds, T2_D);
    wait_idle();
    run(8'h01, 3'd0, 4'd4, 0, 0, 1, N3, xs, xvs, bs, ds);
    chk("t3_x", xs, T3_X); chk("t3_xv", xvs, T3_XV); chk("t3_busy", bs, T3_B); chk("t3_done", ds, T3_D);
    wait_idle();
    @(posedge clk);
    #1 bus.pat = 8'($urandom); bus.len = 3; bus.reps = 2; bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (3) @(posedge clk);
    #2 chk("busy_before_rst", {31'b0, bus.busy}, 1);
    #1 rst = 1;
    #1 chk("midrst_x", {31'b0, bus.x}, 0);
    chk("midrst_xv", {31'b0, bus.xv}, 0);
    chk("midrst_busy", {31'b0, bus.busy}, 0);
    chk("midrst_done", {31'b0, bus.done}, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 bus.start = $urandom_range(3) == 0;
      bus.pat = 8'($urandom);
      bus.len = 3'($urandom);
      bus.reps = 4'($urandom_range(5));
      bus.stop = $urandom_range(11) == 0;
    end
    wait_idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
